mem_access_unit: RTL and testbench

//   Sits between the multicycle control unit and the unified instruction/data memory.

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_timeout_ctr.sv | 29 ++
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the multicycle memory access unit.
package mips_mem_pkg;

  localparam int AW_DEF          = 32;
  localparam int DW_DEF          = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the access unit: request/grant plus one-cycle read-data return.
interface mem_access_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  // Handshake: mem_req is the valid and mem_gnt the ready. A request transfers in the
  // cycle where both are high; until then mem_req, mem_we, mem_addr and mem_wdata are
  // held stable. A write completes on its grant. Read data returns later as a single
  // mem_rvalid cycle with mem_rdata, which the master always accepts (no backpressure).
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter that flags when an access has been outstanding too long.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CW'(TIMEOUT_CYC))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expired during the TIMEOUT_CYC-th enabled cycle, so the abort happens on that edge.
  assign o_expired = i_enable && (r_count >= CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Converts multicycle MemRd/MemWr strobes into req/gnt/rvalid transactions, holds IR/MDR
// and stalls the controller. Optional ALIGN_CHECK_EN adds addr_err for misaligned accesses.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic          ior_d,
  input  logic          ir_wr,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] b_reg,
  output logic          stall,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] mdr,
  output logic          bus_err,
`ifdef ALIGN_CHECK_EN
  output logic          addr_err,
`endif
  output state_t        dbg_state,
  mem_access_unit_if.master bus
);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_dest;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_mdr;
  logic          r_bus_err;

  logic          w_req_start;
  logic          w_accept;
  logic          w_conflict_err;
  logic [AW-1:0] w_new_addr;
  logic          w_misaligned;
  logic          w_expired;
  logic          w_timeout;
  logic          w_capture;
  logic          w_ctr_enable;

  assign w_req_start    = mem_rd ^ mem_wr;
  assign w_accept       = (r_state == IDLE) && w_req_start;
  assign w_conflict_err = (r_state == IDLE) && mem_rd && mem_wr;
  assign w_new_addr     = ior_d ? alu_out : pc;
  assign w_ctr_enable   = (r_state == REQ) || (r_state == RESP);

`ifdef ALIGN_CHECK_EN
  assign w_misaligned = (w_new_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  mem_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_accept),
    .i_enable  (w_ctr_enable),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A completing grant/rvalid wins over an expiry landing in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_start) begin
          w_next = w_misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          w_next = r_we ? DONE : RESP;
        end else if (w_expired) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      RESP: begin
        if (bus.mem_rvalid) begin
          w_next    = DONE;
          w_capture = 1'b1;
        end else if (w_expired) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_dest    <= 1'b0;
      r_ir      <= '0;
      r_mdr     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout | w_conflict_err;
      if (w_accept) begin
        r_addr  <= w_new_addr;
        r_wdata <= b_reg;
        r_we    <= mem_wr;
        r_dest  <= ir_wr;
      end
      if (w_capture) begin
        if (r_dest) begin
          r_ir <= bus.mem_rdata;
        end else begin
          r_mdr <= bus.mem_rdata;
        end
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  logic r_addr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_accept && w_misaligned;
    end
  end

  assign addr_err = r_addr_err;
`endif

  // The IDLE term lets the controller freeze in the same cycle it issues the strobe.
  assign stall = ((r_state != IDLE) && (r_state != DONE)) ||
                 ((r_state == IDLE) && w_req_start);

  assign bus.mem_req   = (r_state == REQ);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign ir        = r_ir;
  assign mdr       = r_mdr;
  assign bus_err   = r_bus_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized transactions against a cycle-count model.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0, ior_d = 1'b0, ir_wr = 1'b0;
  logic [31:0] pc = '0, alu_out = '0, b_reg = '0;
  logic        stall, bus_err;
  logic [31:0] ir, mdr;
  state_t      dbg_state;
`ifdef ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_ir = '0, exp_mdr = '0;

  mem_access_unit_if #(.AW(32), .DW(32)) bus_if ();

  mem_access_unit #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .ior_d(ior_d), .ir_wr(ir_wr),
    .pc(pc), .alu_out(alu_out), .b_reg(b_reg), .stall(stall), .ir(ir), .mdr(mdr), .bus_err(bus_err),
`ifdef ALIGN_CHECK_EN
    .addr_err(addr_err),
`endif
    .dbg_state(dbg_state), .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Expected stall length: one IDLE cycle plus REQ/RESP occupancy capped by the timeout.
  function automatic int model_stall(input bit is_wr, input int dg, input int dr);
    int busy;
    busy = is_wr ? (dg + 1) : (dg + 1 + dr + 1);
    if (busy > TO) busy = TO;
    return 1 + busy;
  endfunction

  function automatic bit model_timeout(input bit is_wr, input int dg, input int dr);
    return (is_wr ? (dg + 1) : (dg + dr + 2)) > TO;
  endfunction

  // Drives one access and plays the memory: grant after dg request cycles, rvalid dr cycles into RESP.
  task automatic run_txn(input bit is_wr, input bit iord, input bit irwr, input logic [31:0] pcv,
                         input logic [31:0] aluv, input logic [31:0] bv, input logic [31:0] rdv,
                         input int dg, input int dr, output int stall_cyc, output int req_cyc,
                         output int err_cnt, output int aerr_cnt, output logic [31:0] addr_seen,
                         output logic we_seen, output logic [31:0] wdata_seen, output bit stable_ok,
                         output bit finished);
    int resp_idx;
    bit granted_rd;
    stall_cyc = 0; req_cyc = 0; err_cnt = 0; aerr_cnt = 0; resp_idx = 0; granted_rd = 0;
    addr_seen = '0; we_seen = 1'b0; wdata_seen = '0; stable_ok = 1; finished = 0;
    @(negedge clk);
    mem_rd = !is_wr; mem_wr = is_wr; ior_d = iord; ir_wr = irwr;
    pc = pcv; alu_out = aluv; b_reg = bv;
    for (int c = 0; c < 200; c++) begin
      bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = $urandom();
      if (bus_if.mem_req === 1'b1) begin
        if (req_cyc == 0) begin
          addr_seen = bus_if.mem_addr; we_seen = bus_if.mem_we; wdata_seen = bus_if.mem_wdata;
        end else if (bus_if.mem_addr !== addr_seen || bus_if.mem_wdata !== wdata_seen || bus_if.mem_we !== we_seen) begin
          stable_ok = 0;
        end
        if (req_cyc == dg) begin
          bus_if.mem_gnt = 1'b1;
          granted_rd = !bus_if.mem_we;
        end
        req_cyc++;
      end else if (granted_rd) begin
        if (resp_idx == dr) begin
          bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = rdv;
        end
        resp_idx++;
      end
      #1;
      if (stall === 1'b1) stall_cyc++;
      if (bus_err === 1'b1) err_cnt++;
`ifdef ALIGN_CHECK_EN
      if (addr_err === 1'b1) aerr_cnt++;
`endif
      if (stall === 1'b0) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (stall !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags stall=%b bus_err=%b want 0 0", stall, bus_err); end
    n_checks++; if (bus_if.mem_req !== 1'b0 || bus_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus req=%b we=%b want 0 0", bus_if.mem_req, bus_if.mem_we); end
    n_checks++; if (ir !== 32'h0 || mdr !== 32'h0) begin n_fail++; $display("FAIL reset_regs ir=%h mdr=%h want 0 0", ir, mdr); end
    n_checks++; if (bus_if.mem_addr !== 32'h0 || bus_if.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_addr addr=%h wdata=%h want 0 0", bus_if.mem_addr, bus_if.mem_wdata); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d want IDLE", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch;
    int sc, rc, ec, ac; logic [31:0] a, wd; logic we; bit st, fin;
    run_txn(0, 0, 1, 32'h0000_0010, 32'h0000_0abc, 32'h0, 32'h8C01_0004, 0, 1, sc, rc, ec, ac, a, we, wd, st, fin);
    exp_ir = 32'h8C01_0004;
    n_checks++; if (!fin || sc != 4) begin n_fail++; $display("FAIL fetch_stall got=%0d want 4 (fin=%0d)", sc, fin); end
    n_checks++; if (a !== 32'h10 || we !== 1'b0) begin n_fail++; $display("FAIL fetch_addr got=%h we=%b want 00000010 0", a, we); end
    n_checks++; if (ir !== exp_ir || mdr !== exp_mdr) begin n_fail++; $display("FAIL fetch_data ir=%h mdr=%h want %h %h", ir, mdr, exp_ir, exp_mdr); end
  endtask

  task automatic test_load;
    int sc, rc, ec, ac; logic [31:0] a, wd; logic we; bit st, fin;
    run_txn(0, 1, 0, 32'h0000_0020, 32'h0000_0044, 32'h0, 32'h1357_9bdf, 0, 0, sc, rc, ec, ac, a, we, wd, st, fin);
    exp_mdr = 32'h1357_9bdf;
    n_checks++; if (!fin || sc != 3) begin n_fail++; $display("FAIL load_stall got=%0d want 3", sc); end
    n_checks++; if (a !== 32'h44) begin n_fail++; $display("FAIL load_addr got=%h want 00000044", a); end
    n_checks++; if (mdr !== exp_mdr || ir !== exp_ir) begin n_fail++; $display("FAIL load_data mdr=%h ir=%h want %h %h", mdr, ir, exp_mdr, exp_ir); end
    n_checks++; if (dbg_state !== DONE) begin n_fail++; $display("FAIL load_done state=%0d want DONE", dbg_state); end
    @(negedge clk); #1;
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL load_idle state=%0d want IDLE", dbg_state); end
  endtask

  task automatic test_store;
    int sc, rc, ec, ac; logic [31:0] a, wd; logic we; bit st, fin;
    run_txn(1, 1, 0, 32'h0000_0030, 32'h0000_0048, 32'hDEAD_BEEF, 32'h0, 3, 0, sc, rc, ec, ac, a, we, wd, st, fin);
    n_checks++; if (!fin || sc != 5) begin n_fail++; $display("FAIL store_stall got=%0d want 5", sc); end
    n_checks++; if (a !== 32'h48 || we !== 1'b1 || wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_bus addr=%h we=%b wdata=%h want 00000048 1 deadbeef", a, we, wd); end
    n_checks++; if (!st || rc != 4) begin n_fail++; $display("FAIL store_req stable=%0d req_cycles=%0d want 1 4", st, rc); end
    n_checks++; if (ir !== exp_ir || mdr !== exp_mdr || ec != 0) begin n_fail++; $display("FAIL store_regs ir=%h mdr=%h err=%0d want %h %h 0", ir, mdr, ec, exp_ir, exp_mdr); end
  endtask

  task automatic test_timeout;
    int sc, rc, ec, ac; logic [31:0] a, wd; logic we; bit st, fin;
    run_txn(0, 0, 1, 32'h0000_0050, 32'h0, 32'h0, 32'h5555_5555, 1000, 0, sc, rc, ec, ac, a, we, wd, st, fin);
    n_checks++; if (!fin || sc != model_stall(0, 1000, 0) || rc != TO) begin n_fail++; $display("FAIL timeout_gnt stall=%0d req=%0d want %0d %0d", sc, rc, model_stall(0, 1000, 0), TO); end
    n_checks++; if (ec != 1 || bus_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_err err=%0d req=%b want 1 0", ec, bus_if.mem_req); end
    @(negedge clk); #1;
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse bus_err=%b want 0", bus_err); end
    run_txn(0, 1, 0, 32'h0, 32'h0000_0060, 32'h0, 32'hAAAA_AAAA, 0, 1000, sc, rc, ec, ac, a, we, wd, st, fin);
    n_checks++; if (!fin || sc != model_stall(0, 0, 1000) || ec != 1) begin n_fail++; $display("FAIL timeout_rv stall=%0d err=%0d want %0d 1", sc, ec, model_stall(0, 0, 1000)); end
    n_checks++; if (ir !== exp_ir || mdr !== exp_mdr) begin n_fail++; $display("FAIL timeout_regs ir=%h mdr=%h want %h %h", ir, mdr, exp_ir, exp_mdr); end
  endtask

  task automatic test_conflict;
    @(negedge clk); mem_rd = 1'b1; mem_wr = 1'b1; #1;
    n_checks++; if (stall !== 1'b0 || bus_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL conflict_stall stall=%b req=%b want 0 0", stall, bus_if.mem_req); end
    @(negedge clk); mem_rd = 1'b0; mem_wr = 1'b0; #1;
    n_checks++; if (bus_err !== 1'b1 || bus_if.mem_req !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL conflict_err bus_err=%b req=%b state=%0d want 1 0 IDLE", bus_err, bus_if.mem_req, dbg_state); end
    @(negedge clk); #1;
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL conflict_pulse bus_err=%b want 0", bus_err); end
  endtask

  task automatic test_spurious;
    @(negedge clk);
    bus_if.mem_gnt = 1'b1; bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; #1;
    n_checks++; if (ir !== exp_ir || mdr !== exp_mdr || bus_if.mem_req !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL spurious ir=%h mdr=%h req=%b want %h %h 0", ir, mdr, bus_if.mem_req, exp_ir, exp_mdr); end
  endtask

  task automatic test_back_to_back;
    int sc, rc, ec, ac; logic [31:0] a, wd; logic we; bit st, fin;
    run_txn(0, 1, 0, 32'h0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 1, 0, sc, rc, ec, ac, a, we, wd, st, fin);
    exp_mdr = 32'h0BAD_F00D;
    run_txn(0, 0, 1, 32'h0000_0104, 32'h0, 32'h0, 32'h2402_0001, 0, 2, sc, rc, ec, ac, a, we, wd, st, fin);
    exp_ir = 32'h2402_0001;
    n_checks++; if (!fin || sc != 5 || a !== 32'h104 || ec != 0) begin n_fail++; $display("FAIL b2b_second stall=%0d addr=%h err=%0d want 5 00000104 0", sc, a, ec); end
    n_checks++; if (ir !== exp_ir || mdr !== exp_mdr) begin n_fail++; $display("FAIL b2b_regs ir=%h mdr=%h want %h %h", ir, mdr, exp_ir, exp_mdr); end
  endtask

  task automatic test_random;
    int sc, rc, ec, ac, dg, dr; logic [31:0] a, wd, pcv, aluv, bv, rdv, exp_a; logic we; bit st, fin, is_wr, iord, irwr;
    for (int t = 0; t < 24; t++) begin
      is_wr = bit'($urandom_range(0, 1)); iord = bit'($urandom_range(0, 1)); irwr = bit'($urandom_range(0, 1));
      pcv = $urandom() & 32'hFFFF_FFFC; aluv = $urandom() & 32'hFFFF_FFFC; bv = $urandom(); rdv = $urandom();
      dg = $urandom_range(0, 5); dr = $urandom_range(0, 5);
      run_txn(is_wr, iord, irwr, pcv, aluv, bv, rdv, dg, dr, sc, rc, ec, ac, a, we, wd, st, fin);
      exp_a = iord ? aluv : pcv;
      if (!is_wr && !model_timeout(is_wr, dg, dr)) begin
        if (irwr) exp_ir = rdv; else exp_mdr = rdv;
      end
      n_checks++; if (!fin || sc != model_stall(is_wr, dg, dr)) begin n_fail++; $display("FAIL rand%0d_stall got=%0d want %0d", t, sc, model_stall(is_wr, dg, dr)); end
      n_checks++; if (a !== exp_a || we !== is_wr || wd !== bv || !st) begin n_fail++; $display("FAIL rand%0d_bus addr=%h we=%b wdata=%h stable=%0d want %h %b %h 1", t, a, we, wd, st, exp_a, is_wr, bv); end
      n_checks++; if (ir !== exp_ir || mdr !== exp_mdr || ec != 0) begin n_fail++; $display("FAIL rand%0d_regs ir=%h mdr=%h err=%0d want %h %h 0", t, ir, mdr, ec, exp_ir, exp_mdr); end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); mem_rd = 1'b1; ir_wr = 1'b0; ior_d = 1'b0; pc = 32'h0000_0200;
    @(negedge clk); bus_if.mem_gnt = 1'b1;
    @(negedge clk); bus_if.mem_gnt = 1'b0;
    rst_n = 1'b0; mem_rd = 1'b0; #1;
    exp_ir = '0; exp_mdr = '0;
    n_checks++; if (bus_if.mem_req !== 1'b0 || stall !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL rstmid_ctrl req=%b stall=%b state=%0d want 0 0 IDLE", bus_if.mem_req, stall, dbg_state); end
    n_checks++; if (ir !== 32'h0 || mdr !== 32'h0) begin n_fail++; $display("FAIL rstmid_regs ir=%h mdr=%h want 0 0", ir, mdr); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = 32'h1234_5678;
    @(negedge clk); bus_if.mem_rvalid = 1'b0; #1;
    n_checks++; if (ir !== 32'h0 || mdr !== 32'h0 || bus_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_late ir=%h mdr=%h req=%b want 0 0 0", ir, mdr, bus_if.mem_req); end
    @(negedge clk); mem_rd = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (bus_if.mem_req !== 1'b1) begin n_fail++; $display("FAIL rstreq_pre req=%b want 1", bus_if.mem_req); end
    rst_n = 1'b0; mem_rd = 1'b0; #1;
    n_checks++; if (bus_if.mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rstreq_drop req=%b stall=%b want 0 0", bus_if.mem_req, stall); end
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_align;
    int sc, rc, ec, ac; logic [31:0] a, wd; logic we; bit st, fin;
    run_txn(0, 1, 0, 32'h0, 32'h0000_0046, 32'h0, 32'h7777_7777, 0, 0, sc, rc, ec, ac, a, we, wd, st, fin);
    n_checks++; if (!fin || rc != 0 || ac != 1 || sc != 1) begin n_fail++; $display("FAIL align_err req=%0d addr_err=%0d stall=%0d want 0 1 1", rc, ac, sc); end
    n_checks++; if (ir !== exp_ir || mdr !== exp_mdr) begin n_fail++; $display("FAIL align_regs ir=%h mdr=%h want %h %h", ir, mdr, exp_ir, exp_mdr); end
    @(negedge clk); #1;
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL align_pulse addr_err=%b want 0", addr_err); end
  endtask
`endif

  initial begin
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_timeout();
    test_conflict();
    test_spurious();
    test_back_to_back();
    test_random();
`ifdef ALIGN_CHECK_EN
    test_align();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
